// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared types and helpers for the flexible single-clock FIFO.
package fifo_flex_pkg;

    // Widest count any instance may need; per-instance counts use a narrower local type.
    localparam int unsigned MaxCountW = 32;
    typedef logic [MaxCountW-1:0] count_wide_t;

    // Bits needed to represent 0..depth inclusive (a full FIFO holds exactly depth).
    function automatic int unsigned clog2_count(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer advance with explicit wrap at depth-1, so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_flex_ram.sv
// fifo_flex_ram: simple dual-port RAM, one write port and one registered read port.
// The storage array is never cleared; only the read register resets.
module fifo_flex_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store on enable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: one-cycle latency, holds its value when not reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with arbitrary depth, optional first-word-fall-through,
// occupancy count, programmable almost flags and sticky overflow/underflow.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned CntW     = clog2_count(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             almost_empty,
    output logic [CntW-1:0]  count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef logic [CntW-1:0] count_t;

    localparam count_t CntFull  = count_t'(DEPTH);
    localparam count_t AfThresh = count_t'(AF_THRESH);
    localparam count_t AeThresh = count_t'(AE_THRESH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    count_t           cnt_q, cnt_d;
    logic [WIDTH-1:0] byp_q, byp_d;
    logic             src_ram_q, src_ram_d;
    logic             overflow_q, underflow_q;
    logic             valid_wr, valid_rd;
    logic             ram_we, ram_re;
    logic [WIDTH-1:0] ram_rdata;

    // In FWFT mode cnt_q is total occupancy including the presented word,
    // so the same flag equations serve both modes.
    assign full         = (cnt_q == CntFull);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AfThresh);
    assign almost_empty = (cnt_q <= AeThresh);
    assign count        = cnt_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign valid_wr = wr_en && !full;
    assign valid_rd = rd_en && !empty;

    // FWFT presents either the bypass register or the RAM read register.
    assign rd_data = ((FWFT != 0) && !src_ram_q) ? byp_q : ram_rdata;

    // Next-state: pointers, occupancy, RAM strobes and FWFT output source.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        byp_d     = byp_q;
        src_ram_d = src_ram_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;

        if (FWFT == 0) begin
            ram_we = valid_wr;
            ram_re = valid_rd;
            if (valid_wr) begin
                wr_ptr_d = PtrW'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (valid_rd) begin
                rd_ptr_d = PtrW'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
        end else begin
            // RAM holds the words behind the presented one. A write that would become
            // the presented word next cycle skips the RAM to avoid its read latency.
            if (valid_wr && (empty || (cnt_q == count_t'(1) && valid_rd))) begin
                byp_d     = wr_data;
                src_ram_d = 1'b0;
            end else if (valid_wr) begin
                ram_we   = 1'b1;
                wr_ptr_d = PtrW'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            // Popping with more words behind: fetch the next one from RAM.
            if (valid_rd && cnt_q >= count_t'(2)) begin
                ram_re    = 1'b1;
                rd_ptr_d  = PtrW'(ptr_inc(32'(rd_ptr_q), DEPTH));
                src_ram_d = 1'b1;
            end
        end

        unique case ({valid_wr, valid_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards contents but leaves the RAM array alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            byp_q       <= '0;
            src_ram_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            byp_q       <= byp_d;
            src_ram_q   <= src_ram_d;
            overflow_q  <= overflow_q | (wr_en & full);
            underflow_q <= underflow_q | (rd_en & empty);
        end
    end

    fifo_flex_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .waddr(wr_ptr_q),
        .wdata(wr_data),
        .re   (ram_re),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    a_wr_not_full: assert property (@(posedge clk) disable iff (!rst_n) valid_wr |-> !full);
    a_rd_not_empty: assert property (@(posedge clk) disable iff (!rst_n) valid_rd |-> !empty);
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntFull);
    a_full_not_empty: assert property (@(posedge clk) disable iff (!rst_n) full |-> !empty);
    a_count_known: assert property (@(posedge clk) rst_n |-> !$isunknown(count));

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: scenario tasks plus randomized traffic against queue-based models,
// for a standard-mode instance (depth 5) and an FWFT instance (depth 4).
module tb_fifo_flex;

    localparam int unsigned W    = 16;
    localparam int unsigned SD   = 5;
    localparam int unsigned FD   = 4;
    localparam int unsigned S_AF = 3;
    localparam int unsigned S_AE = 1;
    localparam int unsigned F_AF = FD - 2;
    localparam int unsigned F_AE = 2;
    localparam int unsigned SCW  = $clog2(SD + 1);
    localparam int unsigned FCW  = $clog2(FD + 1);

    logic           clk;
    logic           rst_n;

    logic           s_wr_en, s_rd_en, s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
    logic [W-1:0]   s_wr_data, s_rd_data;
    logic [SCW-1:0] s_count;

    logic           f_wr_en, f_rd_en, f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
    logic [W-1:0]   f_wr_data, f_rd_data;
    logic [FCW-1:0] f_count;

    fifo_flex #(
        .WIDTH(W), .DEPTH(SD), .FWFT(0), .AF_THRESH(S_AF), .AE_THRESH(S_AE)
    ) u_std (
        .clk(clk), .rst_n(rst_n),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full), .almost_full(s_af),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .empty(s_empty), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_flex #(
        .WIDTH(W), .DEPTH(FD), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_af),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .empty(f_empty), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queues plus sticky flags.
    logic [W-1:0] sq[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] exp_s_rd;
    logic         exp_s_ovf, exp_s_udf, exp_f_ovf, exp_f_udf;

    task automatic model_clear();
        sq.delete();
        fq.delete();
        exp_s_rd  = '0;
        exp_s_ovf = 1'b0;
        exp_s_udf = 1'b0;
        exp_f_ovf = 1'b0;
        exp_f_udf = 1'b0;
    endtask

    // One clock of stimulus on both instances; returns 1 time unit after the edge.
    task automatic cycle(input logic swe, input logic [W-1:0] swd, input logic sre,
                         input logic fwe, input logic [W-1:0] fwd, input logic fre);
        logic svw, svr, fvw, fvr;
        s_wr_en = swe; s_wr_data = swd; s_rd_en = sre;
        f_wr_en = fwe; f_wr_data = fwd; f_rd_en = fre;
        @(posedge clk);
        svw = swe && (sq.size() < SD);
        svr = sre && (sq.size() > 0);
        if (swe && sq.size() == SD) exp_s_ovf = 1'b1;
        if (sre && sq.size() == 0) exp_s_udf = 1'b1;
        if (svr) exp_s_rd = sq.pop_front();
        if (svw) sq.push_back(swd);
        fvw = fwe && (fq.size() < FD);
        fvr = fre && (fq.size() > 0);
        if (fwe && fq.size() == FD) exp_f_ovf = 1'b1;
        if (fre && fq.size() == 0) exp_f_udf = 1'b1;
        if (fvr) void'(fq.pop_front());
        if (fvw) fq.push_back(fwd);
        #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    endtask

    task automatic s_cycle(input logic we, input logic [W-1:0] wd, input logic re);
        cycle(we, wd, re, 1'b0, '0, 1'b0);
    endtask

    task automatic f_cycle(input logic we, input logic [W-1:0] wd, input logic re);
        cycle(1'b0, '0, 1'b0, we, wd, re);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !==
            {SCW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_std_flags: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want 0 1 0 1 0 0 0",
                     s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf);
        end
        checks++;
        if (s_rd_data !== '0 || f_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got std=%h fwft=%h want 0", s_rd_data, f_rd_data);
        end
        checks++;
        if ({f_count, f_empty, f_full, f_ae, f_af} !== {FCW'(0), 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_fwft_flags: got cnt=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     f_count, f_empty, f_full, f_ae, f_af);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            s_cycle(1'b1, W'(i), 1'b0);
            checks++;
            if (s_count !== SCW'(i)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, i);
            end
        end
        checks++;
        if ({s_full, s_empty} !== 2'b10) begin
            errors++;
            $display("FAIL fill_full: got full=%b empty=%b want 1 0", s_full, s_empty);
        end
        s_cycle(1'b1, W'(6), 1'b0);
        checks++;
        if ({s_ovf, s_count, s_full} !== {1'b1, SCW'(5), 1'b1}) begin
            errors++;
            $display("FAIL overflow_write: got ov=%b cnt=%0d full=%b want 1 5 1",
                     s_ovf, s_count, s_full);
        end
        for (int i = 1; i <= 5; i++) begin
            s_cycle(1'b0, '0, 1'b1);
            checks++;
            if (s_rd_data !== W'(i)) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, s_rd_data, W'(i));
            end
        end
        checks++;
        if ({s_empty, s_count} !== {1'b1, SCW'(0)}) begin
            errors++;
            $display("FAIL drain_empty: got empty=%b cnt=%0d want 1 0", s_empty, s_count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) s_cycle(1'b1, W'(20 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            s_cycle(1'b0, '0, 1'b1);
            checks++;
            if (s_rd_data !== W'(20 + i)) begin
                errors++;
                $display("FAIL wrap_pre[%0d]: got %h want %h", i, s_rd_data, W'(20 + i));
            end
        end
        for (int i = 0; i < 4; i++) s_cycle(1'b1, W'(10 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            s_cycle(1'b0, '0, 1'b1);
            checks++;
            if (s_rd_data !== W'(10 + i)) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, s_rd_data, W'(10 + i));
            end
        end
        checks++;
        if (s_count !== SCW'(0)) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 0", s_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        checks++;
        if ({s_ovf, s_udf} !== 2'b00) begin
            errors++;
            $display("FAIL sim_flags_cleared: got ov=%b un=%b want 0 0", s_ovf, s_udf);
        end
        for (int i = 0; i < 5; i++) s_cycle(1'b1, W'(30 + i), 1'b0);
        s_cycle(1'b1, W'(99), 1'b1);
        checks++;
        if ({s_rd_data, s_count, s_ovf, s_full} !== {W'(30), SCW'(4), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sim_full: got rd=%h cnt=%0d ov=%b full=%b want 001e 4 1 0",
                     s_rd_data, s_count, s_ovf, s_full);
        end
        for (int i = 1; i < 5; i++) begin
            s_cycle(1'b0, '0, 1'b1);
            checks++;
            if (s_rd_data !== W'(30 + i)) begin
                errors++;
                $display("FAIL sim_drain[%0d]: got %h want %h", i, s_rd_data, W'(30 + i));
            end
        end
        s_cycle(1'b1, W'(77), 1'b1);
        checks++;
        if ({s_udf, s_count, s_empty, s_rd_data} !== {1'b1, SCW'(1), 1'b0, W'(34)}) begin
            errors++;
            $display("FAIL sim_empty: got un=%b cnt=%0d empty=%b rd=%h want 1 1 0 0022",
                     s_udf, s_count, s_empty, s_rd_data);
        end
        s_cycle(1'b0, '0, 1'b1);
        checks++;
        if ({s_rd_data, s_empty} !== {W'(77), 1'b1}) begin
            errors++;
            $display("FAIL sim_empty_read: got rd=%h empty=%b want 004d 1", s_rd_data, s_empty);
        end
    endtask

    task automatic test_fwft();
        f_cycle(1'b1, W'('hA5), 1'b0);
        checks++;
        if ({f_empty, f_rd_data, f_count} !== {1'b0, W'('hA5), FCW'(1)}) begin
            errors++;
            $display("FAIL fwft_bypass: got empty=%b rd=%h cnt=%0d want 0 00a5 1",
                     f_empty, f_rd_data, f_count);
        end
        f_cycle(1'b0, '0, 1'b1);
        checks++;
        if ({f_empty, f_count} !== {1'b1, FCW'(0)}) begin
            errors++;
            $display("FAIL fwft_pop_empty: got empty=%b cnt=%0d want 1 0", f_empty, f_count);
        end
        for (int i = 0; i < 4; i++) f_cycle(1'b1, W'('h100 + i), 1'b0);
        checks++;
        if ({f_full, f_count, f_rd_data} !== {1'b1, FCW'(4), W'('h100)}) begin
            errors++;
            $display("FAIL fwft_full: got full=%b cnt=%0d rd=%h want 1 4 0100",
                     f_full, f_count, f_rd_data);
        end
        f_cycle(1'b1, W'('h1FF), 1'b1);
        checks++;
        if ({f_rd_data, f_count, f_ovf} !== {W'('h101), FCW'(3), 1'b1}) begin
            errors++;
            $display("FAIL fwft_full_rw: got rd=%h cnt=%0d ov=%b want 0101 3 1",
                     f_rd_data, f_count, f_ovf);
        end
        for (int i = 0; i < 2; i++) begin
            f_cycle(1'b0, '0, 1'b1);
            checks++;
            if (f_rd_data !== fq[0]) begin
                errors++;
                $display("FAIL fwft_pop[%0d]: got %h want %h", i, f_rd_data, fq[0]);
            end
        end
        f_cycle(1'b1, W'('h55), 1'b1);
        checks++;
        if ({f_empty, f_count, f_rd_data} !== {1'b0, FCW'(1), W'('h55)}) begin
            errors++;
            $display("FAIL fwft_one_rw: got empty=%b cnt=%0d rd=%h want 0 1 0055",
                     f_empty, f_count, f_rd_data);
        end
        f_cycle(1'b0, '0, 1'b1);
        f_cycle(1'b0, '0, 1'b1);
        checks++;
        if ({f_empty, f_udf} !== 2'b11) begin
            errors++;
            $display("FAIL fwft_underflow: got empty=%b un=%b want 1 1", f_empty, f_udf);
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        checks++;
        if ({s_af, s_ae} !== 2'b01) begin
            errors++;
            $display("FAIL thr_zero: got af=%b ae=%b want 0 1", s_af, s_ae);
        end
        for (int i = 1; i <= 5; i++) begin
            s_cycle(1'b1, W'(i), 1'b0);
            checks++;
            if ({s_af, s_ae} !== {i >= 3, i <= 1}) begin
                errors++;
                $display("FAIL thr_up[%0d]: got af=%b ae=%b want %b %b",
                         i, s_af, s_ae, i >= 3, i <= 1);
            end
        end
        for (int i = 4; i >= 0; i--) begin
            s_cycle(1'b0, '0, 1'b1);
            checks++;
            if ({s_af, s_ae} !== {i >= 3, i <= 1}) begin
                errors++;
                $display("FAIL thr_down[%0d]: got af=%b ae=%b want %b %b",
                         i, s_af, s_ae, i >= 3, i <= 1);
            end
        end
    endtask

    task automatic test_async_reset();
        s_cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(40 + i), 1'b0, 1'b1, W'(50 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_count, s_empty, s_ovf, s_udf, s_rd_data} !==
            {SCW'(0), 1'b1, 1'b0, 1'b0, W'(0)}) begin
            errors++;
            $display("FAIL async_reset_std: got cnt=%0d e=%b ov=%b un=%b rd=%h want 0 1 0 0 0",
                     s_count, s_empty, s_ovf, s_udf, s_rd_data);
        end
        checks++;
        if ({f_count, f_empty} !== {FCW'(0), 1'b1}) begin
            errors++;
            $display("FAIL async_reset_fwft: got cnt=%0d e=%b want 0 1", f_count, f_empty);
        end
        model_clear();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_cycle(1'b1, W'(7), 1'b0);
        s_cycle(1'b0, '0, 1'b1);
        checks++;
        if ({s_rd_data, s_empty} !== {W'(7), 1'b1}) begin
            errors++;
            $display("FAIL async_reset_reuse: got rd=%h empty=%b want 0007 1", s_rd_data, s_empty);
        end
    endtask

    task automatic test_random();
        logic [SCW+6+W-1:0] exp_s, act_s;
        logic [FCW+5:0]     exp_f, act_f;
        int ssz, fsz, wp, rp;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            // Alternate write-heavy and read-heavy phases so full and empty are both hit.
            wp = ((n / 40) % 2 == 0) ? 75 : 30;
            rp = 105 - wp;
            cycle($urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < rp,
                  $urandom_range(0, 99) < wp, W'($urandom), $urandom_range(0, 99) < rp);
            ssz = sq.size();
            fsz = fq.size();
            exp_s = {SCW'(ssz), ssz == SD, ssz >= S_AF, ssz == 0, ssz <= S_AE,
                     exp_s_ovf, exp_s_udf, exp_s_rd};
            act_s = {s_count, s_full, s_af, s_empty, s_ae, s_ovf, s_udf, s_rd_data};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL random_std[%0d]: got %h want %h", n, act_s, exp_s);
            end
            exp_f = {FCW'(fsz), fsz == FD, fsz >= F_AF, fsz == 0, fsz <= F_AE,
                     exp_f_ovf, exp_f_udf};
            act_f = {f_count, f_full, f_af, f_empty, f_ae, f_ovf, f_udf};
            checks++;
            if (act_f !== exp_f) begin
                errors++;
                $display("FAIL random_fwft[%0d]: got %h want %h", n, act_f, exp_f);
            end
            if (fsz > 0) begin
                checks++;
                if (f_rd_data !== fq[0]) begin
                    errors++;
                    $display("FAIL random_fwft_data[%0d]: got %h want %h", n, f_rd_data, fq[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_wr_en   = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        f_wr_en   = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
        model_clear();
        #2;
        test_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_thresholds();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised successor to the team's single-clock FIFO. Adds:
- non-power-of-two depth;
- a selectable first-word-fall-through (FWFT) read mode;
- occupancy count and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags.

It serves as the general-purpose buffer between streaming stages in testbench and RTL designs.

Parameters:
WIDTH, 16, data width in bits (>=1)
DEPTH, 32, capacity in entries, any integer >=2 (power of two not required)
FWFT, 0, 0 = standard mode (rd_data one cycle after rd_en); 1 = first-word-fall-through (rd_data valid whenever !empty)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
rd_en  in  1  read request (FWFT: acknowledge/pop of current rd_data)
rd_data  out  WIDTH  read data
empty  out  1  no readable word
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  entries held, including any FWFT output register
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values while rst_n=0: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0, rd_data=0.
  - Reset mid-operation discards all contents immediately.
  - The RAM array is not cleared.
- Write and read qualification:
  - valid_wr = wr_en && !full.
  - valid_rd = rd_en && !empty.
  - Flags are sampled at the start of the cycle.
  - A rejected request has no effect except setting its error flag.
- Pointers: wr_ptr and rd_ptr have range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. There is no modulo-2^n aliasing.
- Count rules:
  - Increments on valid_wr && !valid_rd.
  - Decrements on valid_rd && !valid_wr.
  - Unchanged when both are valid.
  - full, empty, almost_full and almost_empty are derived from registered count (standard mode) or from the total occupancy rule below (FWFT).
  - All flags update the cycle after the causing edge.
- Simultaneous read and write:
  - When full: the read is valid, the write is rejected and overflow is set; count becomes DEPTH-1.
  - When empty in standard mode: the write is valid, the read is rejected and underflow is set.
- Standard mode (FWFT=0):
  - rd_data is registered. It presents the word at rd_ptr one cycle after a valid_rd and holds its value otherwise.
  - Write-to-empty-deassert latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data is valid whenever empty=0.
  - valid_rd pops the presented word; the next word appears on the following cycle, or empty asserts.
  - A write into an empty FIFO bypasses the RAM: empty deasserts and rd_data=wr_data on the next cycle (latency 1).
  - Total capacity, including the output register, is exactly DEPTH. count reflects total occupancy.
  - A simultaneous write and pop with count==1 keeps empty=0 and presents the new word next cycle.
- overflow and underflow:
  - They are sticky until reset.
  - Both set on the cycle after the offending request.
- Assertions required in RTL:
  - valid_wr |-> !full
  - valid_rd |-> !empty
  - count <= DEPTH
  - full |-> !empty
  - $isunknown(count)==0 when rst_n=1

Decomposition:
- Package fifo_flex_pkg holds:
  - function clog2_count(DEPTH) returning the count width;
  - typedef of the count type for a given width;
  - a wrap-increment function ptr_inc(ptr, DEPTH).
- One sub-module: fifo_flex_ram. It is a simple dual-port RAM (one write port, one registered read port, 1-cycle read latency, parameters WIDTH and DEPTH). FWFT prefetch, bypass and output-register logic stay in fifo_flex.

Test Plan:
1. DEPTH=5, FWFT=0: write 1..5 -> full=1 after 5th, count=5. Write 6 -> rejected, overflow=1. Read 5 times -> rd_data 1,2,3,4,5 each one cycle after rd_en, then empty=1.
2. DEPTH=5, wrap-around: 3 writes, 3 reads, 4 writes (values 10..13), 4 reads -> rd_data 10,11,12,13 with pointers wrapping past 4. count returns to 0.
3. DEPTH=5, full with simultaneous wr_en=rd_en=1 (write 99) -> read pops oldest, write rejected, overflow=1, count=4. Empty with both asserted -> write accepted, underflow=1, count=1.
4. FWFT=1, DEPTH=4: single write 0xA5 into empty -> next cycle empty=0, rd_data=0xA5 without rd_en. Pop -> empty=1 next cycle. Fill to 4 -> full=1, count=4.
5. AF_THRESH=3, AE_THRESH=1, DEPTH=5: step count 0->5->0 -> almost_empty=1 for count<=1, almost_full=1 for count>=3, each transition one cycle after the edge.
6. Assert rst_n=0 asynchronously mid-stream at count=3 -> empty=1, count=0 and error flags=0 without waiting for a clk edge. After release, writing 7 then reading returns 7.
